lc3_controller: RTL
===================

// Module: lc3_controller
// PURPOSE
//  Multi-cycle LC-3 control FSM sitting directly upstream of the datapath. It drives every datapath
//  load/enable/select strobe and the memory handshake. It consumes IR and the N/Z/P flags.
//  Subset executed: ADD, AND, NOT, BR, JMP, LD, LDR, LDI, LEA, ST, STR, STI. Other opcodes behave as NOP.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles waited for mem_rdy before asserting err and returning to FETCH0
// PORTS
//  clk         in   1   system clock, all state changes on posedge
//  rst         in   1   asynchronous, active-low reset
//  IR          in   16  instruction register from datapath
//  N,Z,P       in   1   condition flags from datapath
//  mem_rdy     in   1   memory completes current access this cycle
//  mem_en      out  1   memory access request (MAR valid)
//  mem_we      out  1   1=write MDR to mem[MAR], 0=read
//  enaPC,enaMDR,enaALU,enaMARM  out 1  bus tri-state enables, at most one high per cycle
//  ldPC,ldIR,ldMAR,ldMDR,regWE,flagWE  out 1  register load strobes
//  selPC  out 2  0=PC+1 1=EAB 2=bus;   selEAB2 out 2  0=0 1=off6 2=off9 3=off11
//  selEAB1,selMAR,selMDR  out 1  EAB base (1=SR1), MARM src (1=IR[7:0]), MDR src (1=mem)
//  aluControl  out 2  00 ADD, 01 AND, 10 NOT, 11 PASS SR1
//  SR1,SR2,DR  out 3  register file addresses
//  err         out 1  sticky memory-timeout flag, cleared only by reset
// BEHAVIOUR
//  Reset (rst=0, async): state=FETCH0, all strobes/enables 0, selects 0, err=0, timeout counter=0.
//  Outputs are Moore-decoded from the state register and IR. Any signal not listed for a state is 0.
//  States and transitions:
//   FETCH0: enaPC, ldMAR -> FETCH1
//   FETCH1: mem_en, ldPC (selPC=0). ldMDR+selMDR only when mem_rdy. Stay until mem_rdy -> FETCH2.
//           ldPC is high only in the first FETCH1 cycle; PC increments exactly once.
//   FETCH2: enaMDR, ldIR -> DECODE
//   DECODE: branch on IR[15:12]; undefined opcode -> FETCH0
//   ALU (ADD/AND/NOT): enaALU, regWE, flagWE, DR=IR[11:9], SR1=IR[8:6], SR2=IR[2:0],
//        aluControl=IR[15:14] -> FETCH0
//   BR: if (IR[11]&N)|(IR[10]&Z)|(IR[9]&P) then ldPC, selPC=1, selEAB1=0, selEAB2=2 -> FETCH0
//   JMP: ldPC, selPC=1, selEAB1=1, selEAB2=0, SR1=IR[8:6] -> FETCH0
//   LEA: enaMARM, selEAB2=2, regWE, flagWE, DR=IR[11:9] -> FETCH0
//   ADDR (LD/LDI/ST/STI: selEAB2=2, selEAB1=0; LDR/STR: selEAB2=1, selEAB1=1, SR1=IR[8:6]):
//        enaMARM, ldMAR -> RD (LD/LDR/LDI) or SDATA (ST/STR/STI). STI enters RD first for indirection.
//   RD: mem_en, read; on mem_rdy ldMDR, selMDR=1 -> LDI/STI first pass: IND else LDRES
//   IND: enaMDR, ldMAR -> RD (LDI second read) or SDATA (STI)
//   LDRES: enaMDR, regWE, flagWE, DR=IR[11:9] -> FETCH0
//   SDATA: enaALU, aluControl=11, SR1=IR[11:9], ldMDR, selMDR=0 -> WR
//   WR: mem_en, mem_we; on mem_rdy -> FETCH0
//  Indirection pass tracked by a 1-bit flag: set on IND, cleared in FETCH0.
//  Timeout counter: counts cycles spent in FETCH1/RD/WR with mem_rdy=0 and clears on state exit.
//   When it reaches MEM_TIMEOUT-1: err=1, mem_en drops, next state FETCH0.
//   An instruction aborted this way has no register or flag side effects.
//  mem_en stays high and MAR stays constant until mem_rdy (no request withdrawal).
//  mem_rdy arriving in the request's first cycle is legal: minimum memory stage is 1 cycle.
//  Reset mid-instruction abandons it immediately. No partial regWE/flagWE after reset release.
//  Bus exclusivity: never more than one ena* high in any cycle, including during reset.
// TESTING
//  1 Reset then mem_rdy tied 1, mem[0]=0x1261 (ADD R1,R1,#1): FETCH0..ALU takes 5 cycles;
//    regWE/flagWE high once, DR=1, aluControl=00.
//  2 BRz with Z=1, IR=0x0405: ldPC with selPC=1, selEAB2=2 in BR state.
//    Same with Z=0 and P=0: no ldPC; PC advances by 1 only.
//  3 LDI with mem_rdy delayed 3 cycles per access: RD visited twice, IND once, LDRES regWE once.
//    mem_en held high through all wait cycles.
//  4 STR R2,R3,#-1 (0x74FF): ADDR selEAB1=1, selEAB2=1, SR1=3.
//    SDATA aluControl=11, SR1=2. WR mem_we=1 until mem_rdy.
//  5 mem_rdy held 0 in FETCH1 with MEM_TIMEOUT=16: err rises after 16 cycles, FSM returns to FETCH0.
//    err stays 1 until rst=0.
//  6 Assert rst=0 during WR: outputs 0 asynchronously. After release: FETCH0 with no mem_we.
//    Bus-enable one-hot assertion checked throughout all tests.

Source files
------------

// File: rtl/lc3_controller.sv
// Multi-cycle LC-3 control FSM: drives datapath strobes and bus enables, and runs the memory
// handshake with a timeout that raises a sticky error flag.
`timescale 1ns/1ps
module lc3_controller #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] IR,
  input  logic        N,
  input  logic        Z,
  input  logic        P,
  input  logic        mem_rdy,
  output logic        mem_en,
  output logic        mem_we,
  output logic        enaPC,
  output logic        enaMDR,
  output logic        enaALU,
  output logic        enaMARM,
  output logic        ldPC,
  output logic        ldIR,
  output logic        ldMAR,
  output logic        ldMDR,
  output logic        regWE,
  output logic        flagWE,
  output logic [1:0]  selPC,
  output logic [1:0]  selEAB2,
  output logic        selEAB1,
  output logic        selMAR,
  output logic        selMDR,
  output logic [1:0]  aluControl,
  output logic [2:0]  SR1,
  output logic [2:0]  SR2,
  output logic [2:0]  DR,
  output logic        err
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  typedef enum logic [3:0] {
    S_FETCH0, S_FETCH1, S_FETCH2, S_DECODE, S_ALU, S_BR, S_JMP,
    S_LEA, S_ADDR, S_RD, S_IND, S_LDRES, S_SDATA, S_WR
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ind_q, ind_d;
  logic          err_q, err_d;
  logic [3:0]    opcode;
  logic          memState;
  logic          timeout;
  logic          baseOff;
  logic          unused_ir;

  assign opcode    = IR[15:12];
  assign baseOff   = (opcode == OP_LDR) || (opcode == OP_STR);
  assign unused_ir = ^IR[5:3];
  assign memState  = (state_q == S_FETCH1) || (state_q == S_RD) || (state_q == S_WR);
  assign timeout   = memState && (cnt_q == CNT_LAST);
  assign err       = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH0;
      cnt_q   <= '0;
      ind_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ind_q   <= ind_d;
      err_q   <= err_d;
    end
  end

  // Outputs are forced low while reset is held, so no strobe or bus enable leaks out of FETCH0.
  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    ind_d      = ind_q;
    err_d      = err_q;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    enaPC      = 1'b0;
    enaMDR     = 1'b0;
    enaALU     = 1'b0;
    enaMARM    = 1'b0;
    ldPC       = 1'b0;
    ldIR       = 1'b0;
    ldMAR      = 1'b0;
    ldMDR      = 1'b0;
    regWE      = 1'b0;
    flagWE     = 1'b0;
    selPC      = 2'd0;
    selEAB2    = 2'd0;
    selEAB1    = 1'b0;
    selMAR     = 1'b0;
    selMDR     = 1'b0;
    aluControl = 2'b00;
    SR1        = 3'd0;
    SR2        = 3'd0;
    DR         = 3'd0;
    if (rst && timeout) begin
      state_d = S_FETCH0;
      err_d   = 1'b1;
    end else if (rst) begin
      if (memState && !mem_rdy) cnt_d = cnt_q + CW'(1);
      unique case (state_q)
        S_FETCH0: begin
          enaPC   = 1'b1;
          ldMAR   = 1'b1;
          ind_d   = 1'b0;
          state_d = S_FETCH1;
        end
        S_FETCH1: begin
          mem_en = 1'b1;
          ldPC   = (cnt_q == '0);
          if (mem_rdy) begin
            ldMDR   = 1'b1;
            selMDR  = 1'b1;
            state_d = S_FETCH2;
          end
        end
        S_FETCH2: begin
          enaMDR  = 1'b1;
          ldIR    = 1'b1;
          state_d = S_DECODE;
        end
        S_DECODE: begin
          case (opcode)
            OP_ADD, OP_AND, OP_NOT:                 state_d = S_ALU;
            OP_BR:                                  state_d = S_BR;
            OP_JMP:                                 state_d = S_JMP;
            OP_LEA:                                 state_d = S_LEA;
            OP_LD, OP_LDR, OP_LDI, OP_ST, OP_STR, OP_STI: state_d = S_ADDR;
            default:                                state_d = S_FETCH0;
          endcase
        end
        S_ALU: begin
          enaALU     = 1'b1;
          regWE      = 1'b1;
          flagWE     = 1'b1;
          DR         = IR[11:9];
          SR1        = IR[8:6];
          SR2        = IR[2:0];
          aluControl = IR[15:14];
          state_d    = S_FETCH0;
        end
        S_BR: begin
          if ((IR[11] & N) | (IR[10] & Z) | (IR[9] & P)) begin
            ldPC    = 1'b1;
            selPC   = 2'd1;
            selEAB2 = 2'd2;
          end
          state_d = S_FETCH0;
        end
        S_JMP: begin
          ldPC    = 1'b1;
          selPC   = 2'd1;
          selEAB1 = 1'b1;
          SR1     = IR[8:6];
          state_d = S_FETCH0;
        end
        S_LEA: begin
          enaMARM = 1'b1;
          selEAB2 = 2'd2;
          regWE   = 1'b1;
          flagWE  = 1'b1;
          DR      = IR[11:9];
          state_d = S_FETCH0;
        end
        S_ADDR: begin
          enaMARM = 1'b1;
          ldMAR   = 1'b1;
          selEAB2 = baseOff ? 2'd1 : 2'd2;
          selEAB1 = baseOff;
          SR1     = baseOff ? IR[8:6] : 3'd0;
          state_d = ((opcode == OP_ST) || (opcode == OP_STR)) ? S_SDATA : S_RD;
        end
        // LDI and STI pass through here twice: the first read fetches the pointer.
        S_RD: begin
          mem_en = 1'b1;
          if (mem_rdy) begin
            ldMDR   = 1'b1;
            selMDR  = 1'b1;
            state_d = (((opcode == OP_LDI) || (opcode == OP_STI)) && !ind_q) ? S_IND : S_LDRES;
          end
        end
        S_IND: begin
          enaMDR  = 1'b1;
          ldMAR   = 1'b1;
          ind_d   = 1'b1;
          state_d = (opcode == OP_STI) ? S_SDATA : S_RD;
        end
        S_LDRES: begin
          enaMDR  = 1'b1;
          regWE   = 1'b1;
          flagWE  = 1'b1;
          DR      = IR[11:9];
          state_d = S_FETCH0;
        end
        S_SDATA: begin
          enaALU     = 1'b1;
          aluControl = 2'b11;
          SR1        = IR[11:9];
          ldMDR      = 1'b1;
          state_d    = S_WR;
        end
        S_WR: begin
          mem_en = 1'b1;
          mem_we = 1'b1;
          if (mem_rdy) state_d = S_FETCH0;
        end
        default: state_d = S_FETCH0;
      endcase
    end
  end

endmodule
